dmem_access_unit: RTL and testbench

Data-memory access unit for the multicycle datapath. It is the memory-side responder to the store-size (`tam`) and write/read strobes issued by the control unit. It turns doubleword, word, half and byte stores into aligned 64-bit memory writes, with read-modify-write for partial stores. It also extracts and extends sub-doubleword loads. It sits between the control unit/datapath and a synchronous single-port 64-bit data memory.

---
 rtl/dmem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_dmem_access_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns sized stores into aligned 64-bit writes (read-modify-write
// for partial stores) and extracts/extends sized loads from a synchronous 64-bit memory.
module dmem_access_unit #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_write,
    input  logic              req_read,
    input  logic [1:0]        tam,
    input  logic              ld_unsigned,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_we,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_off;
    logic [1:0]        r_tam;
    logic              r_uns;
    logic              r_is_wr;
    logic [63:0]       r_wdata;
    logic              r_err;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [63:0]       r_mem_wdata;
    logic [63:0]       r_rdata;

    logic              w_misaligned;
    logic [7:0]        w_bmask;
    logic [63:0]       w_wrep;
    logic [63:0]       w_merged;
    logic [63:0]       w_lane;
    logic              w_sx;
    logic [63:0]       w_ext;
    logic              w_unused_addr;

    assign w_unused_addr = &{1'b0, addr[63:MEM_AW+3]};

    always_comb begin
        w_misaligned = 1'b0;
        case (tam)
            2'b00:   w_misaligned = |addr[2:0];
            2'b01:   w_misaligned = |addr[1:0];
            2'b10:   w_misaligned = addr[0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Byte-lane mask of the store, positioned at the byte offset; store data shifted to match.
    always_comb begin
        w_bmask = 8'h00;
        case (r_tam)
            2'b00:   w_bmask = 8'hFF;
            2'b01:   w_bmask = 8'h0F;
            2'b10:   w_bmask = 8'h03;
            default: w_bmask = 8'h01;
        endcase
        w_bmask  = w_bmask << r_off;
        w_wrep   = r_wdata << {r_off, 3'b000};
        w_merged = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (w_bmask[i]) w_merged[i*8 +: 8] = w_wrep[i*8 +: 8];
        end
    end

    always_comb begin
        w_lane = mem_rdata >> {r_off, 3'b000};
        w_sx   = ~r_uns;
        w_ext  = w_lane;
        case (r_tam)
            2'b00:   w_ext = w_lane;
            2'b01:   w_ext = {{32{w_sx & w_lane[31]}}, w_lane[31:0]};
            2'b10:   w_ext = {{48{w_sx & w_lane[15]}}, w_lane[15:0]};
            default: w_ext = {{56{w_sx & w_lane[7]}},  w_lane[7:0]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_tam       <= '0;
            r_uns       <= 1'b0;
            r_is_wr     <= 1'b0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_write || req_read) begin
                        r_off      <= addr[2:0];
                        r_tam      <= tam;
                        r_uns      <= ld_unsigned;
                        r_is_wr    <= req_write;
                        r_wdata    <= wdata;
                        r_mem_addr <= addr[MEM_AW+2:3];
                        r_busy     <= 1'b1;
                        if ((req_write && req_read) || w_misaligned) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (req_write && tam == 2'b00) begin
                            r_err       <= 1'b0;
                            r_mem_wdata <= wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (r_is_wr) begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WRITE;
                    end else begin
                        r_rdata <= w_ext;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit: byte-level reference model of memory, loads and
// per-cycle handshake timing, plus directed cases with literal expected values.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_write, req_read, ld_unsigned;
    logic [1:0]  tam;
    logic [63:0] addr, wdata, rdata, mem_wdata, mem_rdata;
    logic        busy, done, err, mem_we;
    logic [7:0]  mem_addr;

    dmem_access_unit #(.MEM_AW(8)) dut (
        .clk(clk), .reset(reset), .req_write(req_write), .req_read(req_read),
        .tam(tam), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0] mem     [0:255];
    logic [63:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model state: cycle k after the accepting edge, expected completion cycle and write cycle.
    bit          active = 0, in_reset = 1;
    int          k = 0, exp_L = 0, we_cyc = 0;
    logic        exp_err;
    logic [7:0]  exp_idx;
    logic [63:0] exp_wd, model_rdata = 64'h0;

    always @(negedge clk) begin
        if (!in_reset) begin
            chk("busy", busy, active);
            chk("done", done, active && k == exp_L);
            if (active && k == exp_L) chk("err", err, exp_err);
            chk("mem_we", mem_we, active && k == we_cyc);
            if (active && k == we_cyc) begin
                chk("mem_addr", mem_addr, exp_idx);
                chk("mem_wdata", mem_wdata, exp_wd);
            end
            chk("rdata", rdata, model_rdata);
        end
    end

    task automatic txn(bit wr, bit rd, logic [1:0] t, bit u, logic [63:0] a,
                       logic [63:0] wd, int poke = 0, int stop_at = 0);
        int          sz  = 1 << (3 - t);
        int          off = int'(a[2:0]);
        logic [7:0]  idx = a[10:3];
        logic [63:0] old = ref_mem[idx];
        logic [63:0] nw  = old;
        logic [63:0] rv  = 64'h0;
        bit          e   = (wr && rd) || (a % sz != 0);
        for (int b = 0; b < sz; b++) begin
            if (off + b < 8) begin
                nw[(off+b)*8 +: 8] = wd[b*8 +: 8];
                rv[b*8 +: 8]       = old[(off+b)*8 +: 8];
            end
        end
        if (!u && rv[sz*8-1])
            for (int b = sz; b < 8; b++) rv[b*8 +: 8] = 8'hFF;
        exp_L   = e ? 1 : (wr ? (t == 2'b00 ? 2 : 4) : 3);
        we_cyc  = (e || !wr) ? 0 : exp_L - 1;
        exp_err = e;
        exp_idx = idx;
        exp_wd  = nw;
        @(negedge clk); #1;
        req_write = wr; req_read = rd; tam = t; ld_unsigned = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_write = 0; req_read = 0;
        active = 1; k = 1;
        while (k <= exp_L) begin
            if (poke != 0 && k == poke) req_read = 1;
            if (poke != 0 && k == poke + 1) req_read = 0;
            if (stop_at != 0 && k == stop_at) return;
            if (k == exp_L && !e) begin
                if (wr) ref_mem[idx] = nw;
                else    model_rdata  = rv;
            end
            @(posedge clk); #1;
            k++;
        end
        active = 0;
        req_read = 0;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        reset = 0; req_write = 0; req_read = 0; tam = 0; ld_unsigned = 0; addr = 0; wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        mem[5] = 64'h0;                  ref_mem[5] = 64'h0;
        mem[2] = 64'hFFFF_FFFF_FFFF_FFFF; ref_mem[2] = mem[2];
        mem[1] = 64'h0000_0000_8000_00F0; ref_mem[1] = mem[1];
        #12;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);  chk("rst_err", err, 0);
        chk("rst_we", mem_we, 0);   chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0); chk("rst_rdata", rdata, 0);
        @(negedge clk); #1; reset = 1; in_reset = 0;

        txn(1, 0, 2'b00, 0, 64'h28, 64'h1122334455667788);
        chk("sd_lit", mem[5], 64'h1122334455667788);
        txn(1, 0, 2'b11, 0, 64'h13, 64'hAB);
        chk("sb_lit", mem[2], 64'hFFFFFFFFABFFFFFF);
        txn(1, 0, 2'b10, 0, 64'h16, 64'h1234);
        chk("sh_lit", mem[2], 64'h1234FFFFABFFFFFF);
        txn(0, 1, 2'b11, 0, 64'h08, 0);
        chk("lb_lit", rdata, 64'hFFFFFFFFFFFFFFF0);
        txn(0, 1, 2'b11, 1, 64'h08, 0);
        chk("lbu_lit", rdata, 64'h00000000000000F0);
        txn(0, 1, 2'b10, 0, 64'h0A, 0);
        chk("lh_lit", rdata, 64'hFFFFFFFFFFFF8000);
        txn(0, 1, 2'b10, 0, 64'h0C, 0);
        chk("lh_hi_lit", rdata, 64'h0);
        txn(1, 0, 2'b01, 0, 64'h0A, 64'hDEADBEEF);
        chk("mis_lit", mem[1], 64'h0000_0000_8000_00F0);
        txn(1, 1, 2'b11, 0, 64'h08, 64'h55);
        chk("conf_lit", mem[1], 64'h0000_0000_8000_00F0);
        txn(0, 1, 2'b00, 0, 64'h08, 0, 2);
        chk("busy_lit", rdata, 64'h0000_0000_8000_00F0);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] a  = {$urandom, $urandom};
            logic [1:0]  t  = 2'($urandom_range(0, 3));
            int          r  = $urandom_range(0, 9);
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~(3'((1 << (3 - t)) - 1));
            txn(r == 0 || r < 5, r == 0 || r >= 5, t, bit'($urandom_range(0, 1)),
                a, {$urandom, $urandom});
        end

        // Abort a partial store while it is in its write cycle.
        txn(1, 0, 2'b11, 0, 64'h43, 64'h77, 0, 3);
        @(negedge clk); #2;
        reset = 0; in_reset = 1; active = 0;
        #1;
        chk("abort_we", mem_we, 0);   chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);   chk("abort_err", err, 0);
        chk("abort_addr", mem_addr, 0); chk("abort_wdata", mem_wdata, 0);
        chk("abort_rdata", rdata, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("abort_mem", mem[8], ref_mem[8]);
        model_rdata = 64'h0;
        @(negedge clk); #1; reset = 1; in_reset = 0;
        txn(0, 1, 2'b00, 0, 64'h40, 0);
        @(negedge clk); @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
